btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, the number of consecutive equal synchronized samples required to accept a new key pattern (5 ms at 50 MHz); legal range 1..2^24.
REQ-002 The block SHALL have parameter RAW_ACTIVE_LOW, default 1; 1 means a raw key line at 0 is a press.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port key_raw, input, 4 bits: raw, bouncing push-button lines, asynchronous to clk.
REQ-006 The block SHALL have port btn, output, 4 bits: the chord code, nonzero for exactly one cycle per completed key press, 4'b0000 otherwise; this port drives the lock FSM btn input directly.
REQ-007 The block SHALL have port pressed, output, 1 bit: 1 while the debounced key vector is nonzero.

Function
REQ-008 key_raw SHALL pass through a two-flop synchronizer, then be normalized to active-high (inverted when RAW_ACTIVE_LOW=1), giving sync[3:0].
REQ-009 Debounce SHALL be vector-wide: a counter tracks consecutive cycles in which sync equals a candidate value, and restarts at 1 whenever sync differs from the candidate, loading the candidate with sync.
REQ-010 When the counter reaches DEBOUNCE_CYCLES, stable[3:0] SHALL take the candidate on that edge; the counter SHALL saturate and not wrap.
REQ-011 Any sync pattern lasting fewer than DEBOUNCE_CYCLES cycles SHALL NOT change stable.
REQ-012 The FSM SHALL have exactly three states: IDLE, CHORD and EMIT.
REQ-013 IDLE: chord=0. Move to CHORD when stable is nonzero, and load chord with stable.
REQ-014 CHORD: chord <= chord | stable each cycle, so the code is the OR of all keys held during the press. When stable becomes 0, move to EMIT.
REQ-015 EMIT: btn = chord for this one cycle, then clear chord and go to IDLE unconditionally, even if keys are pressed again in this cycle; that new press is picked up from IDLE on the next cycle.
REQ-016 btn SHALL be registered and SHALL be 4'b0000 in every state except EMIT.
REQ-017 A partial release (for example 0011 to 0001) SHALL NOT emit; a pulse occurs only after full release.
REQ-018 Latency: a clean raw change updates stable 2+DEBOUNCE_CYCLES cycles later (±1). The btn pulse appears the cycle after stable reaches 0.
REQ-019 pressed SHALL equal (stable != 0), registered.
REQ-020 The block SHALL produce at most one btn pulse per press-release cycle, regardless of bounce or of how long the keys are held.

Reset
REQ-021 While rst=0, all of the following SHALL be forced immediately, without waiting for a clock edge: state=IDLE; synchronizer flops, candidate and stable at the released value (sync=0); counter=0; chord=0; btn=0; pressed=0.
REQ-022 Reset asserted during CHORD or EMIT SHALL discard the chord, and no pulse SHALL appear after reset.
REQ-023 Keys held through reset release SHALL be treated as a new press: debounced, accumulated, and emitted on release.

Verification (DEBOUNCE_CYCLES=4, RAW_ACTIVE_LOW=1)
REQ-024 Clean press: key_raw 1111 to 1110 for 10 cycles, then 1111 -> one pulse btn=0001, and pressed high for about 10 cycles before it.
REQ-025 Bounce: key_raw toggles 1110/1111 every 2 cycles for 12 cycles, then holds 1110 for 8 cycles, then holds 1111 -> stable never changes during the toggling, then exactly one pulse btn=0001.
REQ-026 Rolling chord: keys go 1110 (6 cycles) -> 0110 (6) -> 0111 (6) -> 1111 -> exactly one pulse btn=1001, with no pulse at the partial release.
REQ-027 Glitch: key_raw=1011 for 3 cycles within an idle period -> btn stays 0000 and pressed stays 0.
REQ-028 Reset mid-chord: hold 1100 for 8 cycles, assert rst low for 1 cycle, release keys -> no pulse; then press 0111 and release -> btn=1000 once.
REQ-029 Lock integration: press chords in the order that produces 0111, 1101, 1101 (raw 1000, 0010, 0010) -> the lock's unlocked output goes high after the third pulse.

Source files
------------

// File: rtl/btn_conditioner.sv
`default_nettype none
// btn_conditioner: synchronizes and debounces four push-buttons, then emits one chord code per press.
// Revision 1.0
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned RAW_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw,
  output logic [3:0] btn,
  output logic       pressed
);

  localparam int unsigned CW = 25;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [3:0] RAW_IDLE = (RAW_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHORD = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  logic [3:0]    meta, sync_q, sync;
  logic [3:0]    cand, stable, chord;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    state;

  // Synchronizer resets to the released raw level so sync starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= RAW_IDLE;
      sync_q <= RAW_IDLE;
    end else begin
      meta   <= key_raw;
      sync_q <= meta;
    end
  end

  assign sync = (RAW_ACTIVE_LOW != 0) ? ~sync_q : sync_q;

  always_comb begin
    cnt_nxt = cnt;
    if (sync != cand)
      cnt_nxt = CW'(1);
    else if (cnt != DB_MAX)
      cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand   <= 4'h0;
      cnt    <= '0;
      stable <= 4'h0;
    end else begin
      cand <= sync;
      cnt  <= cnt_nxt;
      if (cnt_nxt == DB_MAX)
        stable <= sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      chord   <= 4'h0;
      btn     <= 4'h0;
      pressed <= 1'b0;
    end else begin
      pressed <= (stable != 4'h0);
      btn     <= 4'h0;
      case (state)
        IDLE: begin
          chord <= stable;
          if (stable != 4'h0)
            state <= CHORD;
        end
        CHORD: begin
          if (stable == 4'h0) begin
            btn   <= chord;
            state <= EMIT;
          end else begin
            chord <= chord | stable;
          end
        end
        EMIT: begin
          chord <= 4'h0;
          state <= IDLE;
        end
        default: begin
          chord <= 4'h0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// tb_btn_conditioner: scoreboard bench; expected chord codes are queued as stimulus is driven.
// Revision 1.0
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] btn;
  logic       pressed;

  int nchk = 0;
  int nbad = 0;
  int pcount = 0;
  logic [3:0] expq[$];
  logic [11:0] hist = 12'h000;
  logic unlocked;

  btn_conditioner #(.DEBOUNCE_CYCLES(4), .RAW_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw), .btn(btn), .pressed(pressed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bench-side lock: opens once the last three pulses are 0111, 1101, 1101.
  assign unlocked = (hist == 12'h7DD);

  always @(negedge clk) begin
    if (pressed) pcount <= pcount + 1;
    if (btn != 4'h0) begin
      if (expq.size() == 0) check("spurious", {28'h0, btn}, 32'h0);
      else check("pulse", {28'h0, btn}, {28'h0, expq.pop_front()});
      hist <= {hist[7:0], btn};
    end
  end

  task automatic hold(input logic [3:0] raw, input int n);
    key_raw = raw;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (expq.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(tag, expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    #1 rst = 1'b0;
    #1;
    check("rst_btn", {28'h0, btn}, 32'h0);
    check("rst_pressed", {31'h0, pressed}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    hold(4'hF, 8);
    check("idle_pressed", {31'h0, pressed}, 32'h0);

    // Clean press
    p0 = pcount;
    expq.push_back(4'b0001);
    hold(4'b1110, 10);
    hold(4'b1111, 12);
    drain("clean_drain", 20);
    check("clean_len_ok", ((pcount - p0) >= 9 && (pcount - p0) <= 11) ? 1 : 0, 1);

    // Bounce: short pulses must never reach stable
    p0 = pcount;
    for (int i = 0; i < 3; i++) begin
      hold(4'b1110, 2);
      hold(4'b1111, 2);
    end
    check("bounce_quiet", pcount - p0, 0);
    expq.push_back(4'b0001);
    hold(4'b1110, 8);
    hold(4'b1111, 12);
    drain("bounce_drain", 20);

    // Rolling chord with a partial release
    expq.push_back(4'b1001);
    hold(4'b1110, 6);
    hold(4'b0110, 6);
    check("roll_pressed", {31'h0, pressed}, 32'h1);
    hold(4'b0111, 6);
    check("roll_partial_q", expq.size(), 1);
    hold(4'b1111, 12);
    drain("roll_drain", 20);

    // Glitch shorter than the debounce window
    p0 = pcount;
    hold(4'b1011, 3);
    hold(4'b1111, 10);
    check("glitch_pressed", pcount - p0, 0);

    // Reset mid-chord discards it
    hold(4'b1100, 8);
    check("mid_pressed", {31'h0, pressed}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_pressed", {31'h0, pressed}, 32'h0);
    key_raw = 4'b1111;
    @(posedge clk);
    #1 rst = 1'b1;
    hold(4'b1111, 15);
    check("rst_nopulse_q", expq.size(), 0);
    expq.push_back(4'b1000);
    hold(4'b0111, 8);
    hold(4'b1111, 12);
    drain("rst_drain", 20);

    // Lock sequence 0111, 1101, 1101
    expq.push_back(4'b0111);
    hold(4'b1000, 8);
    hold(4'b1111, 12);
    expq.push_back(4'b1101);
    hold(4'b0010, 8);
    hold(4'b1111, 12);
    check("lock_early", {31'h0, unlocked}, 32'h0);
    expq.push_back(4'b1101);
    hold(4'b0010, 8);
    hold(4'b1111, 12);
    drain("lock_drain", 20);
    check("lock_open", {31'h0, unlocked}, 32'h1);

    hold(4'b1111, 10);
    check("final_pending", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
`default_nettype wire
